// File: rtl/stopwatch_mmss_pkg.sv
// Shared types and constants for the MM:SS count-up stopwatch.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE,
        ST_LIMIT
    } state_t;

    localparam int unsigned SEG_MAX   = 59;
    localparam int unsigned DEF_SEG_W = 6;
    localparam int unsigned DEF_MIN_W = 7;

endpackage

// File: rtl/stopwatch_mmss_if.sv
// Button/switch inputs and MM:SS display outputs of the stopwatch mode.
interface stopwatch_mmss_if
    import stopwatch_pkg::*;
#(
    parameter int unsigned SEG_W = DEF_SEG_W,
    parameter int unsigned MIN_W = DEF_MIN_W
);
    logic             switch1;
    logic             switch2;
    logic             startStop;
    logic             clear;
    logic             lap;
    logic             running;
    logic             limitAlarma;
    logic [SEG_W-1:0] segundosT;
    logic [MIN_W-1:0] minutosT;
    logic [SEG_W-1:0] lapSegundosT;
    logic [MIN_W-1:0] lapMinutosT;
    logic             lapValid;

    modport master (
        output switch1, switch2, startStop, clear, lap,
        input  running, limitAlarma, segundosT, minutosT,
               lapSegundosT, lapMinutosT, lapValid
    );

    modport slave (
        input  switch1, switch2, startStop, clear, lap,
        output running, limitAlarma, segundosT, minutosT,
               lapSegundosT, lapMinutosT, lapValid
    );
endinterface

// File: rtl/stopwatch_mmss_rise_detect.sv
// Registered rising-edge detector for a button level (sync active-high reset).
module rise_detect (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_rise
);
    logic r_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_q <= 1'b0;
        else       r_q <= i_d;
    end

    assign o_rise = i_d & ~r_q;
endmodule

// File: rtl/stopwatch_mmss.sv
// Count-up MM:SS stopwatch saturating at MAX_MIN:59.
// Lap capture is built only when STOPWATCH_LAP_EN is defined.
module stopwatch_mmss
    import stopwatch_pkg::*;
#(
    parameter int unsigned MAX_MIN = 99,
    parameter int unsigned SEG_W   = DEF_SEG_W,
    parameter int unsigned MIN_W   = DEF_MIN_W
) (
    input  logic             clk1hz,
    input  logic             reset,
    stopwatch_mmss_if.slave  bus
);
    state_t           r_state,   w_state_nxt;
    logic [SEG_W-1:0] r_seg,     w_seg_nxt;
    logic [MIN_W-1:0] r_min,     w_min_nxt;
    logic [SEG_W-1:0] r_lap_seg, w_lap_seg_nxt;
    logic [MIN_W-1:0] r_lap_min, w_lap_min_nxt;
    logic             r_lap_vld, w_lap_vld_nxt;
    logic             r_alarm,   w_alarm_nxt;

    logic             w_en, w_ss_rise, w_lap_rise;
    logic [SEG_W:0]   w_seg_inc;
    logic [MIN_W:0]   w_min_inc;
    logic [SEG_W-1:0] w_cnt_seg;
    logic [MIN_W-1:0] w_cnt_min;
    logic             w_at_ceil, w_hit_ceil;

    assign w_en = bus.switch1 & ~bus.switch2;

    rise_detect u_ss_rise (
        .i_clk  (clk1hz),
        .i_rst  (reset),
        .i_d    (bus.startStop),
        .o_rise (w_ss_rise)
    );

`ifdef STOPWATCH_LAP_EN
    rise_detect u_lap_rise (
        .i_clk  (clk1hz),
        .i_rst  (reset),
        .i_d    (bus.lap),
        .o_rise (w_lap_rise)
    );
`else
    assign w_lap_rise = 1'b0;
`endif

    // Increment at full width so the 59/MAX_MIN compares never see a wrapped value.
    assign w_seg_inc  = {1'b0, r_seg} + (SEG_W+1)'(1);
    assign w_min_inc  = {1'b0, r_min} + (MIN_W+1)'(1);
    assign w_at_ceil  = (r_seg == SEG_W'(SEG_MAX)) && (r_min == MIN_W'(MAX_MIN));
    assign w_hit_ceil = (w_cnt_seg == SEG_W'(SEG_MAX)) && (w_cnt_min == MIN_W'(MAX_MIN));

    always_comb begin
        w_cnt_seg = w_seg_inc[SEG_W-1:0];
        w_cnt_min = r_min;
        if (w_seg_inc > (SEG_W+1)'(SEG_MAX)) begin
            w_cnt_seg = '0;
            w_cnt_min = w_min_inc[MIN_W-1:0];
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_seg_nxt     = r_seg;
        w_min_nxt     = r_min;
        w_lap_seg_nxt = r_lap_seg;
        w_lap_min_nxt = r_lap_min;
        w_lap_vld_nxt = r_lap_vld;
        w_alarm_nxt   = r_alarm;
        if (w_en) begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_ss_rise) w_state_nxt = ST_RUN;
                end
                ST_RUN: begin
                    if (w_lap_rise) begin
                        w_lap_seg_nxt = r_seg;
                        w_lap_min_nxt = r_min;
                        w_lap_vld_nxt = 1'b1;
                    end
                    if (w_ss_rise) begin
                        w_state_nxt = ST_PAUSE;
                    end else if (w_at_ceil) begin
                        w_state_nxt = ST_LIMIT;
                        w_alarm_nxt = 1'b1;
                    end else begin
                        w_seg_nxt = w_cnt_seg;
                        w_min_nxt = w_cnt_min;
                        if (w_hit_ceil) begin
                            w_state_nxt = ST_LIMIT;
                            w_alarm_nxt = 1'b1;
                        end
                    end
                end
                ST_PAUSE, ST_LIMIT: begin
                    if (bus.clear) begin
                        w_state_nxt   = ST_IDLE;
                        w_seg_nxt     = '0;
                        w_min_nxt     = '0;
                        w_lap_seg_nxt = '0;
                        w_lap_min_nxt = '0;
                        w_lap_vld_nxt = 1'b0;
                        w_alarm_nxt   = 1'b0;
                    end else if (w_ss_rise && r_state == ST_PAUSE) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk1hz) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_seg     <= '0;
            r_min     <= '0;
            r_lap_seg <= '0;
            r_lap_min <= '0;
            r_lap_vld <= 1'b0;
            r_alarm   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_seg     <= w_seg_nxt;
            r_min     <= w_min_nxt;
            r_lap_seg <= w_lap_seg_nxt;
            r_lap_min <= w_lap_min_nxt;
            r_lap_vld <= w_lap_vld_nxt;
            r_alarm   <= w_alarm_nxt;
        end
    end

    assign bus.running      = (r_state == ST_RUN);
    assign bus.limitAlarma  = r_alarm;
    assign bus.segundosT    = r_seg;
    assign bus.minutosT     = r_min;
    assign bus.lapSegundosT = r_lap_seg;
    assign bus.lapMinutosT  = r_lap_min;
    assign bus.lapValid     = r_lap_vld;
endmodule

// File: tb/tb_stopwatch_mmss.sv
// Directed bench: a default-ceiling stopwatch and a MAX_MIN=2 one share the same stimulus.
module tb_stopwatch_mmss;
    localparam bit LAP = `ifdef STOPWATCH_LAP_EN 1'b1 `else 1'b0 `endif;

    logic clk1hz = 1'b0;
    logic reset  = 1'b1;
    logic sw1 = 1'b0, sw2 = 1'b0, ss = 1'b0, clr = 1'b0, lapb = 1'b0;
    int   tests  = 0;
    int   failed = 0;

    always #5 clk1hz = ~clk1hz;

    stopwatch_mmss_if #(.SEG_W(6), .MIN_W(7)) bus_a ();
    stopwatch_mmss_if #(.SEG_W(6), .MIN_W(7)) bus_b ();

    assign bus_a.switch1 = sw1;  assign bus_b.switch1 = sw1;
    assign bus_a.switch2 = sw2;  assign bus_b.switch2 = sw2;
    assign bus_a.startStop = ss; assign bus_b.startStop = ss;
    assign bus_a.clear = clr;    assign bus_b.clear = clr;
    assign bus_a.lap = lapb;     assign bus_b.lap = lapb;

    stopwatch_mmss #(.MAX_MIN(99), .SEG_W(6), .MIN_W(7)) dut_a (
        .clk1hz (clk1hz), .reset (reset), .bus (bus_a.slave));
    stopwatch_mmss #(.MAX_MIN(2), .SEG_W(6), .MIN_W(7)) dut_b (
        .clk1hz (clk1hz), .reset (reset), .bus (bus_b.slave));

    task automatic step(input int n);
        repeat (n) @(posedge clk1hz);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_a(input string tag, input int mm, input int s, input bit run);
        check({tag, " a.min"}, 32'(bus_a.minutosT), 32'(mm));
        check({tag, " a.seg"}, 32'(bus_a.segundosT), 32'(s));
        check({tag, " a.run"}, 32'(bus_a.running), 32'(run));
    endtask

    task automatic check_b(input string tag, input int mm, input int s, input bit run, input bit alm);
        check({tag, " b.min"}, 32'(bus_b.minutosT), 32'(mm));
        check({tag, " b.seg"}, 32'(bus_b.segundosT), 32'(s));
        check({tag, " b.run"}, 32'(bus_b.running), 32'(run));
        check({tag, " b.alarm"}, 32'(bus_b.limitAlarma), 32'(alm));
    endtask

    initial begin
        // Reset
        step(2);
        reset = 1'b0;
        check_a("reset", 0, 0, 0);
        check("reset a.alarm", 32'(bus_a.limitAlarma), 0);
        check("reset a.lapValid", 32'(bus_a.lapValid), 0);

        // Start: first edge enters RUN without counting, then 75 increments
        sw1 = 1'b1; ss = 1'b1; step(1); ss = 1'b0;
        check_a("start", 0, 0, 1);
        step(75);
        check_a("run75", 1, 15, 1);
        check_b("run75", 1, 15, 1, 0);
        clr = 1'b1; step(1); clr = 1'b0;
        check_a("clear_in_run", 1, 16, 1);
        ss = 1'b1; step(1); ss = 1'b0;
        check_a("pause", 1, 16, 0);
        clr = 1'b1; step(1); clr = 1'b0;
        check_a("clear_pause", 0, 0, 0);

        // Pause at 00:10, hold, then clear beats startStop
        ss = 1'b1; step(1); ss = 1'b0;
        step(10);
        ss = 1'b1; step(1); ss = 1'b0;
        step(5);
        check_a("hold10", 0, 10, 0);
        ss = 1'b1; clr = 1'b1; step(1); ss = 1'b0; clr = 1'b0;
        check_a("clr_beats_ss", 0, 0, 0);
        step(2);
        check_a("idle_stays", 0, 0, 0);

        // Held button gives one edge: stays running for several cycles
        ss = 1'b1; step(4); ss = 1'b0;
        check_a("held_ss", 0, 3, 1);
        step(4);
        lapb = 1'b1; step(1); lapb = 1'b0;
        check_a("lap7_cnt", 0, 8, 1);
        check("lap7 seg", 32'(bus_a.lapSegundosT), LAP ? 32'd7 : 32'd0);
        check("lap7 min", 32'(bus_a.lapMinutosT), 0);
        check("lap7 valid", 32'(bus_a.lapValid), LAP ? 32'd1 : 32'd0);
        step(22);
        lapb = 1'b1; step(1); lapb = 1'b0;
        check_a("lap30_cnt", 0, 31, 1);
        check("lap30 seg", 32'(bus_a.lapSegundosT), LAP ? 32'd30 : 32'd0);

        // Disable via switch2 freezes the count, state stays RUN
        sw2 = 1'b1; step(4);
        check_a("disabled", 0, 31, 1);
        sw2 = 1'b0; step(1);
        check_a("reenabled", 0, 32, 1);

        // Reset mid-run
        reset = 1'b1; step(1); reset = 1'b0;
        check_a("reset_mid", 0, 0, 0);
        check("reset_mid lapValid", 32'(bus_a.lapValid), 0);
        check("reset_mid lapSeg", 32'(bus_a.lapSegundosT), 0);

        // Ceiling: MAX_MIN=2 saturates at 02:59, default keeps going
        ss = 1'b1; step(1); ss = 1'b0;
        step(178);
        check_b("pre_ceil", 2, 58, 1, 0);
        step(1);
        check_b("ceil", 2, 59, 0, 1);
        check_a("ceil_ref", 2, 59, 1);
        step(1);
        check_b("no_wrap", 2, 59, 0, 1);
        check_a("past_ceil", 3, 0, 1);
        ss = 1'b1; step(1); ss = 1'b0;
        check_b("ss_in_limit", 2, 59, 0, 1);
        check_a("pause300", 3, 0, 0);
        step(1);
        lapb = 1'b1; step(1); lapb = 1'b0;
        check("lap_in_limit b.valid", 32'(bus_b.lapValid), 0);
        clr = 1'b1; step(1); clr = 1'b0;
        check_b("clr_limit", 0, 0, 0, 0);
        check_a("clr_a", 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
